// File: rtl/ternary_exec_monitor_pkg.sv
// Shared ternary encodings and status codes for the run monitor.
// Optional feature macro used by this slice: TEXEC_RETIRE_COUNT_EN.
package ternary_exec_monitor_pkg;

    localparam logic [1:0] TRIT_ZERO    = 2'b00;
    localparam logic [1:0] TRIT_POS     = 2'b01;
    localparam logic [1:0] TRIT_NEG     = 2'b10;
    localparam logic [1:0] INVALID_TRIT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_HALTED  = 2'b10,
        ST_TIMEOUT = 2'b11
    } status_e;

    function automatic logic signed [1:0] trit_val(logic [1:0] t);
        unique case (1'b1)
            (t == TRIT_POS): return 2'sd1;
            (t == TRIT_NEG): return -2'sd1;
            default:         return 2'sd0;
        endcase
    endfunction

endpackage

// File: rtl/ternary_exec_monitor_if.sv
// Monitor bus: CPU taps, run control/status and converter handshake.
// retire_count exists only with TEXEC_RETIRE_COUNT_EN.
interface ternary_exec_monitor_if #(
    parameter int TRITS = 9,
    parameter int BIN_W = 16,
    parameter int CNT_W = 32
);
    logic                    executing;
    logic                    clear;
    logic [2*TRITS-1:0]      pc;
    logic [2:0]              cpu_state;
    logic [1:0]              status;
    logic                    done;
    logic [CNT_W-1:0]        cycle_count;
    logic                    conv_start;
    logic [2*TRITS-1:0]      conv_in;
    logic                    conv_busy;
    logic                    conv_done;
    logic signed [BIN_W-1:0] conv_out;
    logic                    conv_invalid;
`ifdef TEXEC_RETIRE_COUNT_EN
    logic [CNT_W-1:0]        retire_count;
`endif

    modport master (
`ifdef TEXEC_RETIRE_COUNT_EN
        input  retire_count,
`endif
        output executing, clear, pc, cpu_state,
        output conv_start, conv_in,
        input  status, done, cycle_count,
        input  conv_busy, conv_done, conv_out, conv_invalid
    );

    modport slave (
`ifdef TEXEC_RETIRE_COUNT_EN
        output retire_count,
`endif
        input  executing, clear, pc, cpu_state,
        input  conv_start, conv_in,
        output status, done, cycle_count,
        output conv_busy, conv_done, conv_out, conv_invalid
    );

endinterface

// File: rtl/ternary_exec_monitor_s2b.sv
// Trit-serial ternary to signed binary converter, MSB-first Horner.
// A start on the done cycle is accepted back-to-back.
module ternary_serial_to_bin
    import ternary_exec_monitor_pkg::*;
#(
    parameter int TRITS = 9,
    parameter int BIN_W = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [2*TRITS-1:0]      din,
    output logic                    busy,
    output logic                    done,
    output logic signed [BIN_W-1:0] dout,
    output logic                    invalid
);

    localparam int CW = $clog2(TRITS + 1);

    logic [2*TRITS-1:0]      sh_q;
    logic signed [BIN_W-1:0] acc_q;
    logic signed [BIN_W-1:0] acc_d;
    logic [CW-1:0]           cnt_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    inv_q;
    logic                    accept;
    logic [1:0]              head;
    logic                    head_bad;

    assign accept   = start && (!busy_q || done_q);
    assign head     = accept ? din[2*TRITS-1 -: 2] : sh_q[2*TRITS-1 -: 2];
    assign head_bad = (head == INVALID_TRIT);

    // The first trit is folded in on the accept edge itself.
    always_comb begin
        acc_d = BIN_W'(trit_val(head));
        if (!accept)
            acc_d = (acc_q <<< 1) + acc_q + BIN_W'(trit_val(head));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            inv_q   <= 1'b0;
            dout    <= '0;
            invalid <= 1'b0;
        end else if (accept) begin
            sh_q   <= {din[2*TRITS-3:0], 2'b00};
            acc_q  <= acc_d;
            inv_q  <= head_bad;
            cnt_q  <= CW'(1);
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q && !done_q) begin
            sh_q  <= {sh_q[2*TRITS-3:0], 2'b00};
            acc_q <= acc_d;
            inv_q <= inv_q | head_bad;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(TRITS - 1)) begin
                done_q  <= 1'b1;
                dout    <= acc_d;
                invalid <= inv_q | head_bad;
            end
        end else begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/ternary_exec_monitor.sv
// Run monitor: halt detection, cycle budget, cycle counter, converter.
// TEXEC_RETIRE_COUNT_EN adds a saturating PC-change counter.
module ternary_exec_monitor
    import ternary_exec_monitor_pkg::*;
#(
    parameter int TRITS          = 9,
    parameter int BIN_W          = 16,
    parameter int HALT_CYCLES    = 5,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 32,
    parameter int FETCH_STATE    = 0
) (
    input logic clock,
    input logic reset,
    ternary_exec_monitor_if.slave bus
);

    localparam int ST_W = $clog2(HALT_CYCLES + 1);

    status_e            state_q;
    status_e            state_d;
    logic               done_q;
    logic               done_d;
    logic [CNT_W-1:0]   cyc_q;
    logic [CNT_W-1:0]   cyc_d;
    logic [ST_W-1:0]    stable_q;
    logic [ST_W-1:0]    stable_d;
    logic [2*TRITS-1:0] prev_q;
    logic               run_step;
    logic               pc_match;
    logic               hit_halt;
    logic               hit_to;

    assign run_step = (state_q == ST_RUN) && bus.executing;
    assign pc_match = (bus.pc == prev_q)
                   && (bus.cpu_state == 3'(FETCH_STATE));

    always_comb begin
        stable_d = '0;
        if (pc_match)
            stable_d = (stable_q >= ST_W'(HALT_CYCLES))
                     ? stable_q : stable_q + ST_W'(1);
        cyc_d = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);
    end

    // Decide on the values this RUN cycle is about to register.
    assign hit_halt = stable_d >= ST_W'(HALT_CYCLES);
    assign hit_to   = cyc_d >= CNT_W'(TIMEOUT_CYCLES);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (bus.clear) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.executing)
                        state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!bus.executing) begin
                        state_d = ST_IDLE;
                    end else if (hit_halt) begin
                        state_d = ST_HALTED;
                        done_d  = 1'b1;
                    end else if (hit_to) begin
                        state_d = ST_TIMEOUT;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset || bus.clear) begin
            cyc_q    <= '0;
            stable_q <= '0;
            prev_q   <= '1;
        end else if (run_step) begin
            cyc_q    <= cyc_d;
            stable_q <= stable_d;
            prev_q   <= bus.pc;
        end
    end

`ifdef TEXEC_RETIRE_COUNT_EN
    logic [CNT_W-1:0] ret_q;
    logic             pc_chg;

    assign pc_chg = (bus.pc != prev_q) && (prev_q != '1);

    always_ff @(posedge clock) begin
        if (reset || bus.clear)
            ret_q <= '0;
        else if (run_step && pc_chg && !(&ret_q))
            ret_q <= ret_q + CNT_W'(1);
    end

    assign bus.retire_count = ret_q;
`endif

    assign bus.status      = state_q;
    assign bus.done        = done_q;
    assign bus.cycle_count = cyc_q;

    ternary_serial_to_bin #(
        .TRITS (TRITS),
        .BIN_W (BIN_W)
    ) u_s2b (
        .clock   (clock),
        .reset   (reset),
        .start   (bus.conv_start),
        .din     (bus.conv_in),
        .busy    (bus.conv_busy),
        .done    (bus.conv_done),
        .dout    (bus.conv_out),
        .invalid (bus.conv_invalid)
    );

endmodule

// File: tb/tb_ternary_exec_monitor.sv
// Scoreboard bench for ternary_exec_monitor (TIMEOUT_CYCLES=20).
// Covers TEXEC_RETIRE_COUNT_EN when that macro is defined.
module tb_ternary_exec_monitor;
    import ternary_exec_monitor_pkg::*;

    localparam int TRITS = 9;
    localparam int BIN_W = 16;
    localparam int CNT_W = 32;

    typedef struct {
        longint v;
        bit     inv;
        int     due;
    } conv_exp_t;

    logic clock = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   done_cnt = 0;

    conv_exp_t  cq[$];
    logic [1:0] sq[$];

    ternary_exec_monitor_if #(
        .TRITS (TRITS),
        .BIN_W (BIN_W),
        .CNT_W (CNT_W)
    ) bus ();

    ternary_exec_monitor #(
        .TRITS          (TRITS),
        .BIN_W          (BIN_W),
        .HALT_CYCLES    (5),
        .TIMEOUT_CYCLES (20),
        .CNT_W          (CNT_W),
        .FETCH_STATE    (0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic expect_eq(string tag, longint got, longint exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [2*TRITS-1:0] tern(int v);
        logic [2*TRITS-1:0] w;
        int r;
        w = '0;
        for (int i = 0; i < TRITS; i++) begin
            r = ((v % 3) + 3) % 3;
            if (r == 1) begin
                w[2*i +: 2] = TRIT_POS;
                v = (v - 1) / 3;
            end else if (r == 2) begin
                w[2*i +: 2] = TRIT_NEG;
                v = (v + 1) / 3;
            end else begin
                v = v / 3;
            end
        end
        return w;
    endfunction

    function automatic int model(logic [2*TRITS-1:0] w);
        int acc;
        logic [1:0] t;
        acc = 0;
        for (int i = TRITS - 1; i >= 0; i--) begin
            t = w[2*i +: 2];
            acc = acc * 3 + ((t == TRIT_POS) ? 1 : (t == TRIT_NEG) ? -1 : 0);
        end
        return acc;
    endfunction

    always @(negedge clock) begin
        conv_exp_t e;
        if (bus.done) begin
            done_cnt++;
            if (sq.size() == 0) expect_eq("done_unexpected", 1, 0);
            else expect_eq("done_status", bus.status, sq.pop_front());
        end
        if (bus.conv_done) begin
            if (cq.size() == 0) begin
                expect_eq("conv_unexpected", 1, 0);
            end else begin
                e = cq.pop_front();
                expect_eq("conv_out", bus.conv_out, e.v);
                expect_eq("conv_invalid", bus.conv_invalid, e.inv);
                expect_eq("conv_latency", cyc, e.due);
            end
        end
    end

    task automatic do_clear();
        bus.executing = 1'b0;
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        expect_eq("clear_status", bus.status, ST_IDLE);
        expect_eq("clear_cycles", bus.cycle_count, 0);
`ifdef TEXEC_RETIRE_COUNT_EN
        expect_eq("clear_retire", bus.retire_count, 0);
`endif
    endtask

    task automatic start_conv(logic [2*TRITS-1:0] w, longint v, bit inv);
        conv_exp_t e;
        e.v = v;
        e.inv = inv;
        e.due = cyc + TRITS;
        cq.push_back(e);
        bus.conv_in = w;
        bus.conv_start = 1'b1;
        step();
        bus.conv_start = 1'b0;
    endtask

    task automatic drain_conv();
        int n;
        n = 0;
        while (cq.size() > 0 && n < 30) begin
            step();
            n++;
        end
        expect_eq("conv_drain", cq.size(), 0);
        cq.delete();
    endtask

    initial begin
        int n;
        int d0;
        int v;
        logic [2*TRITS-1:0] w;

        reset = 1'b1;
        bus.executing = 1'b0;
        bus.clear = 1'b0;
        bus.pc = '0;
        bus.cpu_state = '0;
        bus.conv_start = 1'b0;
        bus.conv_in = '0;
        step();
        step();
        expect_eq("rst_status", bus.status, ST_IDLE);
        expect_eq("rst_done", bus.done, 0);
        expect_eq("rst_cycles", bus.cycle_count, 0);
        expect_eq("rst_busy", bus.conv_busy, 0);
        expect_eq("rst_conv_done", bus.conv_done, 0);
        expect_eq("rst_conv_out", bus.conv_out, 0);
        expect_eq("rst_conv_inv", bus.conv_invalid, 0);
        reset = 1'b0;

        // halt: PC 0,1,2 then held at 2 in fetch state
        bus.executing = 1'b1;
        step();
        expect_eq("t1_run", bus.status, ST_RUN);
        d0 = done_cnt;
        sq.push_back(ST_HALTED);
        bus.pc = 0;
        step();
        bus.pc = 1;
        step();
        bus.pc = 2;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.status == ST_RUN && n < 20);
        expect_eq("t1_halt_latency", n, 6);
        expect_eq("t1_status", bus.status, ST_HALTED);
        expect_eq("t1_cycles", bus.cycle_count, 8);
`ifdef TEXEC_RETIRE_COUNT_EN
        expect_eq("t1_retire", bus.retire_count, 2);
`endif
        repeat (3) step();
        expect_eq("t1_sticky", bus.status, ST_HALTED);
        expect_eq("t1_done_pulses", done_cnt - d0, 1);

        // timeout: PC changes every cycle
        do_clear();
        bus.executing = 1'b1;
        bus.pc = 0;
        step();
        d0 = done_cnt;
        sq.push_back(ST_TIMEOUT);
        n = 0;
        while (bus.status == ST_RUN && n < 30) begin
            bus.pc = bus.pc + 1'b1;
            step();
            n++;
        end
        expect_eq("t2_run_cycles", n, 20);
        expect_eq("t2_status", bus.status, ST_TIMEOUT);
        expect_eq("t2_cycles", bus.cycle_count, 20);
        repeat (2) step();
        expect_eq("t2_done_pulses", done_cnt - d0, 1);

        // PC held but cpu_state cycles, then executing drops
        do_clear();
        bus.executing = 1'b1;
        bus.pc = 5;
        bus.cpu_state = 0;
        step();
        d0 = done_cnt;
        for (int i = 0; i < 17; i++) begin
            bus.cpu_state = 3'(i % 5);
            step();
        end
        expect_eq("t3_status", bus.status, ST_RUN);
        expect_eq("t3_cycles", bus.cycle_count, 17);
        bus.executing = 1'b0;
        step();
        expect_eq("t3_idle", bus.status, ST_IDLE);
        expect_eq("t3_no_done", done_cnt - d0, 0);

        // halt and timeout land on the same cycle
        do_clear();
        bus.executing = 1'b1;
        bus.cpu_state = 0;
        bus.pc = 0;
        step();
        sq.push_back(ST_HALTED);
        for (int k = 1; k <= 20; k++) begin
            bus.pc = (k <= 15) ? 18'(k - 1) : 18'(14);
            step();
        end
        expect_eq("t6_status", bus.status, ST_HALTED);
        expect_eq("t6_cycles", bus.cycle_count, 20);
        do_clear();

        // converter
        start_conv(tern(1), 1, 1'b0);
        drain_conv();
        start_conv(tern(0), 0, 1'b0);
        drain_conv();
        w = {TRITS{TRIT_NEG}};
        start_conv(w, -9841, 1'b0);
        drain_conv();
        w = tern(100);
        w[9:8] = INVALID_TRIT;
        start_conv(w, model(w), 1'b1);
        drain_conv();
        for (int i = 0; i < 4; i++) begin
            v = int'($urandom_range(19682)) - 9841;
            start_conv(tern(v), v, 1'b0);
            drain_conv();
        end

        // back-to-back start on the done cycle
        start_conv(tern(-1234), -1234, 1'b0);
        n = 0;
        while (!bus.conv_done && n < 30) begin
            step();
            n++;
        end
        start_conv(tern(4321), 4321, 1'b0);
        drain_conv();

        // reset mid-conversion aborts
        start_conv(tern(50), 50, 1'b0);
        repeat (3) step();
        reset = 1'b1;
        cq.delete();
        step();
        reset = 1'b0;
        expect_eq("abort_busy", bus.conv_busy, 0);
        expect_eq("abort_done", bus.conv_done, 0);
        expect_eq("abort_out", bus.conv_out, 0);
        repeat (12) step();

        expect_eq("scoreboard_empty", cq.size() + sq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
